// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address, advances on accepted fetches,
// and handles traps, redirects, stall and halt/resume with a saturating fetch counter.
module pc_unit #(
    parameter int unsigned       XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_VEC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VEC   = 32'h0000_0100,
    parameter int unsigned       STEP       = 4,
    parameter int unsigned       ALIGN_BITS = 2,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             trap_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             fetch_ready_i,
    output logic             fetch_valid_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_next_seq_o,
    output logic             misalign_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    typedef enum logic [1:0] {
        StBoot   = 2'b00,
        StRun    = 2'b01,
        StHalted = 2'b10
    } state_e;

    localparam logic [XLEN-1:0] StepW     = XLEN'(STEP);
    // ALIGN_BITS = 0 yields an all-zero mask, disabling the alignment check.
    localparam logic [XLEN-1:0] AlignMask = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic fire;
    logic target_bad;

    assign target_bad = |(redirect_target_i & AlignMask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (trap_i) begin
                    pc_d = TRAP_VEC;
                end else if (redirect_i) begin
                    if (target_bad) begin
                        pc_d       = TRAP_VEC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = redirect_target_i;
                    end
                end else if (!stall_i && fire) begin
                    pc_d = pc_q + StepW;
                end
                if (fire && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (halt_i) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (trap_i) begin
                    pc_d    = TRAP_VEC;
                    state_d = StRun;
                end else begin
                    if (redirect_i) begin
                        if (target_bad) begin
                            pc_d       = TRAP_VEC;
                            misalign_d = 1'b1;
                        end else begin
                            pc_d = redirect_target_i;
                        end
                    end
                    if (resume_i && !halt_i) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        fetch_valid_o = (state_q == StRun);
        fire          = fetch_valid_o & fetch_ready_i;
        pc_o          = pc_q;
        pc_next_seq_o = pc_q + StepW;
        misalign_o    = misalign_q;
        state_o       = state_q;
        fetch_count_o = cnt_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot, backpressure, priority, misalign, halt/resume,
// wrap-around, counter saturation (narrow instance) and asynchronous reset.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, halt_i, resume_i, trap_i, redirect_i, fetch_ready_i;
    logic [31:0] redirect_target_i;
    logic        fetch_valid_o, misalign_o;
    logic [31:0] pc_o, pc_next_seq_o;
    logic [1:0]  state_o;
    logic [15:0] fetch_count_o;

    logic        s_valid, s_misalign;
    logic [31:0] s_pc, s_next;
    logic [1:0]  s_state;
    logic [1:0]  s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .halt_i            (halt_i),
        .resume_i          (resume_i),
        .trap_i            (trap_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .fetch_ready_i     (fetch_ready_i),
        .fetch_valid_o     (fetch_valid_o),
        .pc_o              (pc_o),
        .pc_next_seq_o     (pc_next_seq_o),
        .misalign_o        (misalign_o),
        .state_o           (state_o),
        .fetch_count_o     (fetch_count_o)
    );

    // Narrow counter copy to reach saturation quickly.
    pc_unit #(.CNT_W(2)) dut_sat (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .halt_i            (halt_i),
        .resume_i          (resume_i),
        .trap_i            (trap_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .fetch_ready_i     (fetch_ready_i),
        .fetch_valid_o     (s_valid),
        .pc_o              (s_pc),
        .pc_next_seq_o     (s_next),
        .misalign_o        (s_misalign),
        .state_o           (s_state),
        .fetch_count_o     (s_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_core(input string tag, input logic [31:0] pc, input logic valid,
                               input logic [1:0] st, input logic [15:0] cnt);
        check({tag, ".pc"}, 64'(pc_o), 64'(pc));
        check({tag, ".valid"}, 64'(fetch_valid_o), 64'(valid));
        check({tag, ".state"}, 64'(state_o), 64'(st));
        check({tag, ".count"}, 64'(fetch_count_o), 64'(cnt));
    endtask

    initial begin
        rst = 1'b0;
        stall_i = 0; halt_i = 0; resume_i = 0; trap_i = 0; redirect_i = 0;
        fetch_ready_i = 1'b1;
        redirect_target_i = '0;
        #1;
        expect_core("reset", 32'h0, 1'b0, 2'b00, 16'd0);
        check("reset.misalign", 64'(misalign_o), 64'd0);
        repeat (3) tick();
        rst = 1'b1;
        expect_core("boot", 32'h0, 1'b0, 2'b00, 16'd0);

        tick(); expect_core("run0", 32'h0, 1'b1, 2'b01, 16'd0);
        check("run0.nextseq", 64'(pc_next_seq_o), 64'h4);
        tick(); expect_core("run1", 32'h4, 1'b1, 2'b01, 16'd1);
        tick(); expect_core("run2", 32'h8, 1'b1, 2'b01, 16'd2);

        fetch_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp.pc", 64'(pc_o), 64'h8);
            check("bp.count", 64'(fetch_count_o), 64'd2);
        end
        fetch_ready_i = 1'b1;
        tick(); expect_core("bp.release", 32'hC, 1'b1, 2'b01, 16'd3);
        check("sat.reach", 64'(s_count), 64'd3);

        trap_i = 1; redirect_i = 1; stall_i = 1; redirect_target_i = 32'h40;
        tick(); expect_core("prio", 32'h100, 1'b1, 2'b01, 16'd4);
        check("prio.misalign", 64'(misalign_o), 64'd0);
        trap_i = 0; stall_i = 0;
        tick(); expect_core("redir", 32'h40, 1'b1, 2'b01, 16'd5);
        check("redir.misalign", 64'(misalign_o), 64'd0);

        redirect_target_i = 32'h42;
        tick(); expect_core("mis", 32'h100, 1'b1, 2'b01, 16'd6);
        check("mis.pulse", 64'(misalign_o), 64'd1);
        redirect_i = 0; fetch_ready_i = 0;
        tick(); check("mis.clear", 64'(misalign_o), 64'd0);
        check("mis.hold", 64'(pc_o), 64'h100);

        redirect_i = 1; redirect_target_i = 32'h40; fetch_ready_i = 1;
        tick(); expect_core("to40", 32'h40, 1'b1, 2'b01, 16'd7);
        redirect_i = 0; halt_i = 1;
        tick(); expect_core("halt", 32'h44, 1'b0, 2'b10, 16'd8);
        halt_i = 0;
        tick(); expect_core("halted", 32'h44, 1'b0, 2'b10, 16'd8);
        halt_i = 1; resume_i = 1;
        tick(); expect_core("halt+resume", 32'h44, 1'b0, 2'b10, 16'd8);
        halt_i = 0;
        tick(); expect_core("resume", 32'h44, 1'b1, 2'b01, 16'd8);
        resume_i = 0;
        tick(); expect_core("resumed", 32'h48, 1'b1, 2'b01, 16'd9);
        halt_i = 1;
        tick(); expect_core("halt2", 32'h4C, 1'b0, 2'b10, 16'd10);
        redirect_i = 1; redirect_target_i = 32'h200;
        tick(); expect_core("halt.redir", 32'h200, 1'b0, 2'b10, 16'd10);
        redirect_i = 0; trap_i = 1;
        tick(); expect_core("halt.trap", 32'h100, 1'b1, 2'b01, 16'd10);
        trap_i = 0; halt_i = 0;

        redirect_i = 1; redirect_target_i = 32'hFFFF_FFFC;
        tick(); expect_core("wrap.pre", 32'hFFFF_FFFC, 1'b1, 2'b01, 16'd11);
        check("wrap.nextseq", 64'(pc_next_seq_o), 64'h0);
        redirect_i = 0;
        tick(); expect_core("wrap", 32'h0, 1'b1, 2'b01, 16'd12);
        tick(); expect_core("post.wrap", 32'h4, 1'b1, 2'b01, 16'd13);
        check("sat.hold", 64'(s_count), 64'd3);

        #2 rst = 1'b0;
        #1;
        expect_core("async", 32'h0, 1'b0, 2'b00, 16'd0);
        check("async.misalign", 64'(misalign_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
